// File: rtl/reg_scan_master.sv
// Scan-chain master: one word-addressed read or write per full rotation of a register file's shift chain.
// Optional build macro REG_SCAN_ZERO_PROTECT_EN turns writes to word 0 into reads (hardwired-zero register).
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module reg_scan_master #(
    parameter int SIZE  = 16,
    parameter int WIDTH = `WORD_LENGTH,
    parameter int DIV   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wr,
    input  logic [$clog2(SIZE)-1:0] addr,
    input  logic [WIDTH-1:0]        wdata,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        rdata,
    output logic                    sClock,
    output logic                    sEnable,
    output logic                    sIn,
    input  logic                    sOut
);

    localparam int AW = $clog2(SIZE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE} state_t;

    state_t           state_reg, state_next;
    logic [DW-1:0]    div_cnt_reg, div_cnt_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [AW-1:0]    word_cnt_reg, word_cnt_next;
    logic             wr_reg;
    logic [AW-1:0]    addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             busy_reg, done_reg, sclock_reg, senable_reg, sin_reg;
    logic             sin_next;
    logic             accept, capture, wr_accept;
    logic             phase_last, bit_last, word_last;

    assign phase_last = (div_cnt_reg == DW'(DIV - 1));
    assign bit_last   = (bit_cnt_reg == BW'(WIDTH - 1));
    assign word_last  = (word_cnt_reg == AW'(SIZE - 1));

    always_comb begin
        wr_accept = wr;
`ifdef REG_SCAN_ZERO_PROTECT_EN
        if (addr == '0) begin
            wr_accept = 1'b0;
        end
`endif
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        word_cnt_next = word_cnt_reg;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept        = 1'b1;
                    state_next    = SETUP;
                    bit_cnt_next  = '0;
                    word_cnt_next = '0;
                end
            end
            SETUP: begin
                state_next    = SHIFT_LO;
                div_cnt_next  = '0;
                bit_cnt_next  = '0;
                word_cnt_next = '0;
            end
            SHIFT_LO: begin
                if (phase_last) begin
                    div_cnt_next = '0;
                    state_next   = SHIFT_HI;
                    capture      = (word_cnt_reg == addr_reg);
                end else begin
                    div_cnt_next = div_cnt_reg + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_last) begin
                    div_cnt_next  = '0;
                    bit_cnt_next  = bit_last ? '0 : bit_cnt_reg + BW'(1);
                    word_cnt_next = bit_last ? word_cnt_reg + AW'(1) : word_cnt_reg;
                    state_next    = (bit_last && word_last) ? DONE : SHIFT_LO;
                end else begin
                    div_cnt_next = div_cnt_reg + DW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sIn is registered, so the bit for the next low phase is chosen from the counters' next values.
    always_comb begin
        sin_next = sin_reg;
        if (state_next == SHIFT_LO && state_reg != SHIFT_LO) begin
            if (wr_reg && word_cnt_next == addr_reg) begin
                sin_next = wdata_reg[bit_cnt_next];
            end else begin
                sin_next = sOut;
            end
        end else if (state_next == IDLE || state_next == DONE) begin
            sin_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            wr_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            shadow_reg   <= '0;
            rdata_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sclock_reg   <= 1'b0;
            senable_reg  <= 1'b0;
            sin_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            word_cnt_reg <= word_cnt_next;
            sin_reg      <= sin_next;
            busy_reg     <= (state_next == SETUP) || (state_next == SHIFT_LO) || (state_next == SHIFT_HI);
            senable_reg  <= (state_next == SETUP) || (state_next == SHIFT_LO) || (state_next == SHIFT_HI);
            sclock_reg   <= (state_next == SHIFT_HI);
            done_reg     <= (state_next == DONE);
            if (accept) begin
                wr_reg    <= wr_accept;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            if (capture) begin
                shadow_reg[bit_cnt_reg] <= sOut;
            end
            if (state_next == DONE) begin
                rdata_reg <= shadow_reg;
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rdata   = rdata_reg;
    assign sClock  = sclock_reg;
    assign sEnable = senable_reg;
    assign sIn     = sin_reg;

endmodule

// File: tb/tb_reg_scan_master.sv
// Bench for reg_scan_master: two masters (DIV=1 and DIV=3) each driving a 4x8-bit shift-register slave,
// with a word-array reference model feeding per-master scoreboards.
module tb_reg_scan_master;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int N     = SIZE * WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A (DIV=1)
    logic       start_a, wr_a, busy_a, done_a, sclk_a, sen_a, sin_a, sout_a;
    logic [1:0] addr_a;
    logic [7:0] wdata_a, rdata_a;
    // DUT B (DIV=3)
    logic       start_b, wr_b, busy_b, done_b, sclk_b, sen_b, sin_b, sout_b;
    logic [1:0] addr_b;
    logic [7:0] wdata_b, rdata_b;

    reg_scan_master #(.SIZE(SIZE), .WIDTH(WIDTH), .DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .wr(wr_a), .addr(addr_a), .wdata(wdata_a),
        .busy(busy_a), .done(done_a), .rdata(rdata_a),
        .sClock(sclk_a), .sEnable(sen_a), .sIn(sin_a), .sOut(sout_a)
    );

    reg_scan_master #(.SIZE(SIZE), .WIDTH(WIDTH), .DIV(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .sClock(sclk_b), .sEnable(sen_b), .sIn(sin_b), .sOut(sout_b)
    );

    // Slave chains: word w bit b lives at chain[w*WIDTH+b]; sOut is bit 0 of word 0.
    logic [31:0] chain_a, chain_b, load_val;
    logic        load_a = 1'b0, load_b = 1'b0;
    int          edges_a = 0, edges_b = 0;

    always @(posedge sclk_a or posedge load_a) begin
        if (load_a) chain_a <= load_val;
        else if (sen_a) chain_a <= {sin_a, chain_a[31:1]};
    end
    always @(posedge sclk_b or posedge load_b) begin
        if (load_b) chain_b <= load_val;
        else if (sen_b) chain_b <= {sin_b, chain_b[31:1]};
    end
    always @(posedge sclk_a) edges_a <= edges_a + 1;
    always @(posedge sclk_b) edges_b <= edges_b + 1;
    assign sout_a = chain_a[0];
    assign sout_b = chain_b[0];

    // Reference model: the register file as an array of words.
    logic [7:0] mem[SIZE];

    function automatic logic [31:0] packed_mem();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    typedef struct {
        logic [7:0]  rdata;
        int          due;
        logic [31:0] chain;
        int          edges0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue_a(input logic w, input logic [1:0] a, input logic [7:0] d,
                           input int abort_at, input int poke_at);
        exp_t       e;
        logic [7:0] saved[SIZE];
        logic       eff;
        int         c0;
        int         n;
        @(posedge clk); #1;
        start_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d;
        c0 = cyc;
        saved = mem;
        eff = w;
`ifdef REG_SCAN_ZERO_PROTECT_EN
        if (a == 2'd0) eff = 1'b0;
`endif
        e.rdata  = mem[a];
        e.due    = c0 + 2 + 2 * N;
        e.edges0 = edges_a;
        if (eff) mem[a] = d;
        e.chain = packed_mem();
        qa.push_back(e);
        $display("[TB] A cmd wr=%0d addr=%0d wdata=%h expect rdata=%h at cycle %0d", w, a, d, e.rdata, e.due);
        @(posedge clk); #1;
        start_a = 1'b0;
        wr_a = 1'($urandom_range(0, 1)); addr_a = 2'($urandom_range(0, 3)); wdata_a = 8'($urandom);
        if (poke_at > 0) begin
            while (cyc < c0 + poke_at) @(posedge clk);
            #1; start_a = 1'b1; addr_a = 2'd3;
            @(posedge clk); #1; start_a = 1'b0;
        end
        if (abort_at > 0) begin
            while (cyc < c0 + abort_at) @(posedge clk);
            #1; rst = 1'b0; #1;
            check("abort_busy", busy_a, 0);
            check("abort_sEnable", sen_a, 0);
            check("abort_sClock", sclk_a, 0);
            check("abort_rdata", rdata_a, 0);
            check("abort_done", done_a, 0);
            void'(qa.pop_back());
            mem = saved;
            repeat (2) @(posedge clk);
            #1; rst = 1'b1;
            load_val = packed_mem();
            load_a = 1'b1; load_b = 1'b1; #1; load_a = 1'b0; load_b = 1'b0;
        end else begin
            n = 0;
            while (n < 2 * N + 10) begin
                @(negedge clk);
                if (done_a) break;
                n++;
            end
            check("done_seen_a", done_a, 1);
        end
    endtask

    task automatic issue_b(input logic [1:0] a);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        start_b = 1'b1; addr_b = a;
        e.rdata  = mem[a];
        e.due    = cyc + 2 + 6 * N;
        e.edges0 = edges_b;
        e.chain  = packed_mem();
        qb.push_back(e);
        $display("[TB] B read addr=%0d expect rdata=%h at cycle %0d", a, e.rdata, e.due);
        @(posedge clk); #1;
        start_b = 1'b0; addr_b = 2'($urandom_range(0, 3));
        n = 0;
        while (n < 6 * N + 10) begin
            @(negedge clk);
            if (done_b) break;
            n++;
        end
        check("done_seen_b", done_b, 1);
    endtask

    // Scoreboard monitors: pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done_a) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done_a: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = qa.pop_front();
                check("rdata_a", rdata_a, e.rdata);
                check("latency_a", cyc, e.due);
                check("chain_a", chain_a, e.chain);
                check("edges_a", edges_a - e.edges0, N);
                check("busy_at_done_a", busy_a, 0);
                $display("[TB] A done cycle %0d rdata=%h chain=%h", cyc, rdata_a, chain_a);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && done_b) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done_b: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = qb.pop_front();
                check("rdata_b", rdata_b, e.rdata);
                check("latency_b", cyc, e.due);
                check("chain_b", chain_b, e.chain);
                check("edges_b", edges_b - e.edges0, N);
                $display("[TB] B done cycle %0d rdata=%h chain=%h", cyc, rdata_b, chain_b);
            end
        end
    end

    // Every sClock phase of the DIV=3 master must last exactly 3 cycles.
    logic prev_b = 1'b0;
    int   run_b = 0;
    logic seen_hi_b = 1'b0;
    always @(negedge clk) begin
        if (!sen_b) begin
            prev_b = 1'b0; run_b = 0; seen_hi_b = 1'b0;
        end else if (sclk_b == prev_b) begin
            run_b++;
        end else begin
            if (prev_b) begin
                check("phase_hi_b", run_b, 3);
                seen_hi_b = 1'b1;
            end else if (seen_hi_b) begin
                check("phase_lo_b", run_b, 3);
            end
            prev_b = sclk_b;
            run_b = 1;
        end
    end

    initial begin
        rst = 1'b0;
        start_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
        start_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        load_val = packed_mem();
        #1; load_a = 1'b1; load_b = 1'b1; #1; load_a = 1'b0; load_b = 1'b0;
        #1;
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_rdata", rdata_a, 0);
        check("reset_sClock", sclk_a, 0);
        check("reset_sEnable", sen_a, 0);
        check("reset_sIn", sin_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        issue_a(1'b0, 2'd2, 8'h00, 0, 0);   // read word 2
        issue_a(1'b1, 2'd1, 8'hA5, 0, 0);   // write returns old word
        issue_a(1'b0, 2'd1, 8'h00, 0, 0);   // read back the write
        issue_a(1'b0, 2'd0, 8'h00, 0, 20);  // start during busy is ignored
        issue_a(1'b1, 2'd0, 8'hFF, 0, 0);   // word 0 write (protected or not)
        issue_a(1'b1, 2'd3, 8'h5A, 30, 0);  // aborted by reset
        for (int i = 0; i < 16; i++) begin
            issue_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 0, 0);
        end

        load_val = packed_mem();
        load_b = 1'b1; #1; load_b = 1'b0;
        issue_b(2'd3);
        issue_b(2'($urandom_range(0, 3)));

        repeat (20) @(posedge clk);
        #1;
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        check("final_chain_a", chain_a, packed_mem());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_scan_master.md
Name: reg_scan_master

Overview:
- Serial scan controller that drives the shift port (sClock/sEnable/sIn/sOut) of the register files from the debug/JTAG side.
- Performs one word-addressed read or write per command by circulating the entire scan chain once.
- Non-target words are recirculated (sOut fed back to sIn), so the chain is left intact apart from the written word.
- Sits between the debug command logic and a register file's scan port.

Parameters:
- SIZE, 16: number of words in the target chain; power of two, >=2.
- WIDTH, `WORD_LENGTH: bits per word.
- DIV, 1: clk cycles per sClock phase, >=1; one bit period = 2*DIV clk cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  command request; sampled only in IDLE.
- wr  input  1  1 = write wdata to addr; 0 = read only.
- addr  input  $clog2(SIZE)  target word index.
- wdata  input  WIDTH  write data.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  pre-command value of the target word.
- sClock  output  1  scan clock; the slave shifts on its rising edge.
- sEnable  output  1  chain shift enable.
- sIn  output  1  serial data to the chain head (MSB end).
- sOut  input  1  serial data from the chain tail (bit 0 of word 0).

Behaviour:
- Reset (async, rst=0): state IDLE, all outputs 0, counters cleared, latched command cleared.
- Reset mid-operation aborts immediately. The chain is left partially rotated; recovery is the slave's concern.

Chain model:
- Chain length N = SIZE*WIDTH.
- Each sClock rising edge while sEnable=1 shifts the chain one bit toward sOut.
- Bits leave in order: word 0 bit 0 first, then up through word SIZE-1 bit WIDTH-1.
- After exactly N shifts the chain is back in its original alignment.

Accepting a command:
- start=1 in IDLE latches wr, addr and wdata. Later changes to these inputs have no effect.
- start while busy=1 is ignored; there is no queueing.

States:
- IDLE: busy=0, sEnable=0, sClock=0. On start, go to SETUP.
- SETUP: one cycle with busy=1, sEnable=1, sClock=0. Clear bitCnt and wordCnt. Go to SHIFT_LO.
- SHIFT_LO: DIV cycles with sClock=0.
  - In the first cycle, drive sIn = wdata_l[bitCnt] if (wr_l and wordCnt==addr_l), else sIn = sOut.
  - In the last cycle, if wordCnt==addr_l, capture sOut into shadow[bitCnt].
  - Then go to SHIFT_HI.
- SHIFT_HI: DIV cycles with sClock=1, sIn held.
  - In the last cycle, advance bitCnt. When bitCnt wraps from WIDTH-1 to 0, increment wordCnt.
  - If this was the N-th bit, go to DONE; otherwise go to SHIFT_LO.
- DONE: one cycle with sEnable=0, sClock=0, busy=0, done=1, rdata=shadow. Go to IDLE.

Timing and outputs:
- Latency: start in cycle 0, SETUP in cycle 1, done=1 in cycle 2+2*DIV*N. A start arriving in the DONE cycle is not accepted; the earliest accepted start is the cycle after done.
- rdata holds its value until the next done; a write returns the old word.
- All outputs are registered, so the slave sees glitch-free sClock, sEnable and sIn.
- Counter widths are $clog2(WIDTH) and $clog2(SIZE); wrap-around is natural at power-of-two sizes.

Optional Feature:
- Macro: REG_SCAN_ZERO_PROTECT_EN.
- Defined: a write with addr==0 is converted to a read, and word 0 is recirculated unchanged. This mirrors the hardwired-zero register 0 of the register files. done and rdata behave as for a read.
- Undefined: address 0 is written like any other word.

Test Plan:
- Setup for all cases: SIZE=4, WIDTH=8, DIV=1, bench slave model = 32-bit shift register. Words 0..3 preloaded {0x11,0x22,0x33,0x44}.
- Read: read addr=2, start at cycle 0 -> done pulse exactly at cycle 66, rdata=0x33, slave contents unchanged, sClock shows 32 rising edges.
- Write: write addr=1, wdata=0xA5 -> rdata=0x22, slave words {0x11,0xA5,0x33,0x44}; a subsequent read of addr 1 returns 0xA5.
- Ignored start: start re-asserted with addr=3 at cycle 20 of an addr=0 read -> ignored; rdata=0x11, exactly one done pulse.
- Reset mid-operation: rst low at cycle 30 of a write -> same cycle busy=0, sEnable=0, sClock=0, rdata=0, done never pulses; the next command after rst=1 is accepted normally.
- Divider: DIV=3, read addr=3 -> done at cycle 2+6*32=194; each sClock high and low phase lasts 3 cycles; rdata=0x44.
- Zero protect: REG_SCAN_ZERO_PROTECT_EN defined, write addr=0, wdata=0xFF -> rdata=0x11, word 0 still 0x11. With the macro undefined, word 0 becomes 0xFF.
